output_port_allocator: RTL
==========================

# output_port_allocator

Per-output-port route allocator for the mesh switch. It receives route reservation requests from the port control logic of all N input ports and grants ownership of one output port to one input at a time. Arbitration is round-robin. The grant is held until the owning input relieves the route. One instance sits beside each output port of the switch, between the input-port control logic (request/status/relieve) and the crossbar (select/lock).

## Interface
Parameters:
- N, 4: number of switch input ports competing for this output.
- REQUEST_WIDTH, 2: width of each input's routeReserveRequest (output-direction code).
- PORT_ID, 0: direction code of this output (0 North, 1 South, 2 West, 3 East).
- COUNT_WIDTH, 16: width of the grant statistics counter.

Ports:
- clk  input  1  switch clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- routeReserveRequestValid  input  N  per-input request valid.
- routeReserveRequest  input  N*REQUEST_WIDTH  per-input requested direction; input i occupies bits [i*REQUEST_WIDTH +: REQUEST_WIDTH].
- routeRelieve  input  N  per-input release pulse, one cycle.
- routeReserveStatus  output  N  one-hot grant to the owning input; all-zero when free.
- crossbarSelect  output  $clog2(N)  index of the owning input; holds its last value when free.
- outputLocked  output  1  high while an owner holds this output.
- grantCount  output  COUNT_WIDTH  number of grants issued; saturates at all-ones.

## Operation
- Eligibility: input i is eligible when routeReserveRequestValid[i]=1 and its request field equals PORT_ID. Requests naming other directions are ignored.
- State machine has two states:
  - FREE. Status is 0 and outputLocked is 0. If any input is eligible, pick a winner and go to LOCKED.
  - LOCKED(owner). routeReserveStatus[owner]=1 and outputLocked=1. On routeRelieve[owner]=1, leave this state.
- On relieve, if another input is eligible in the same cycle, arbitrate immediately and go directly to LOCKED(new). Otherwise go to FREE.
- Round-robin: a priority pointer ptr (reset 0) is kept. The scan order is ptr, ptr+1, …, ptr+N-1, taken mod N. The first eligible input wins. On every grant, ptr becomes (winner+1) mod N. This makes the previous owner lowest priority.
- While LOCKED, requests from every input, including the owner, are ignored. Each requester keeps its valid asserted until it sees its status bit.
- routeRelieve from a non-owner, or in FREE, is ignored.
- During the relieving cycle, the owner's own request is not eligible for the same-cycle re-grant.
- grantCount increments by 1 on each transition into LOCKED, whether from FREE or directly owner-to-owner. It saturates at 2^COUNT_WIDTH-1.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Timing
- Reset values: routeReserveStatus=0, crossbarSelect=0, outputLocked=0, grantCount=0, ptr=0, state FREE. Reset asserted mid-lock drops the grant asynchronously. Outstanding requests are re-arbitrated from ptr=0 after reset release.
- Grant latency: an eligible request sampled at edge t produces status, select and lock visible after edge t, i.e. 1 cycle.
- Release latency: routeRelieve[owner] sampled at edge t clears status after edge t. If another input is eligible at t, the new owner's status appears after the same edge t. There is no idle gap.
- Status, select and lock change only at clock edges, or immediately on rst.
- Handshake: the requester sees routeReserveStatus high and then starts flit transfer. The relieve pulse accompanies the tail flit handshake.
- Simultaneous events: multiple eligible inputs resolve in one cycle by pointer order. Relieve and new requests in the same cycle follow the release rule above.

## Test plan
- Single request: input 2 requests PORT_ID at cycle 0 -> status=4'b0100, crossbarSelect=2, outputLocked=1 from cycle 1; grantCount=1.
- Contention: inputs 0,1,3 request together from reset -> grant order 0, then 1, then 3. Each owner relieves 3 cycles after its grant; each new grant appears on the relieve edge with no gap; grantCount=3.
- Wrong direction: input 1 requests direction PORT_ID+1 (mod 4) -> status stays 0, outputLocked=0, grantCount=0.
- Spurious relieve: input 0 owns; input 2 pulses routeRelieve -> input 0 stays granted. Input 0 relieving afterwards with no requesters -> status=0, outputLocked=0, crossbarSelect stays 0.
- Reset mid-lock: input 3 owns and input 1 is requesting; rst asserted -> all outputs 0 immediately. After release, input 1 is granted 1 cycle later and grantCount=1.
- Saturation: COUNT_WIDTH=2; perform 5 grant/relieve cycles -> grantCount reads 3 and holds.

Source files
------------

// File: rtl/output_port_allocator.sv
// Round-robin route allocator for one switch output port: grants the output to one
// eligible input at a time and holds the grant until that owner relieves it.
module output_port_allocator #(
    parameter int N             = 4,
    parameter int REQUEST_WIDTH = 2,
    parameter int PORT_ID       = 0,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N-1:0]               routeReserveRequestValid,
    input  logic [N*REQUEST_WIDTH-1:0] routeReserveRequest,
    input  logic [N-1:0]               routeRelieve,
    output logic [N-1:0]               routeReserveStatus,
    output logic [$clog2(N)-1:0]       crossbarSelect,
    output logic                       outputLocked,
    output logic [COUNT_WIDTH-1:0]     grantCount
);

    localparam int SEL_W = $clog2(N);

    typedef enum logic {
        FREE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                 r_state;
    logic [N-1:0]           r_status;
    logic [SEL_W-1:0]       r_sel;
    logic                   r_locked;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [SEL_W-1:0]       r_ptr;

    logic [N-1:0]           w_elig;
    logic [N-1:0]           w_cand;
    logic [SEL_W-1:0]       w_idx;
    logic [SEL_W-1:0]       w_win;
    logic                   w_found;
    logic                   w_owner_relieve;

    function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] win);
        if (int'(win) == N - 1) return '0;
        return win + 1'b1;
    endfunction

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] c);
        if (&c) return c;
        return c + 1'b1;
    endfunction

    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_elig[i] = routeReserveRequestValid[i] &&
                        (routeReserveRequest[i*REQUEST_WIDTH +: REQUEST_WIDTH] ==
                         REQUEST_WIDTH'(PORT_ID));
        end
    end

    // The relieving owner may not win the same-cycle re-grant.
    always_comb begin
        w_cand = w_elig;
        if (r_state == LOCKED) w_cand[r_sel] = 1'b0;
    end

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = SEL_W'((int'(r_ptr) + k) % N);
            if (!w_found && w_cand[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_owner_relieve = (r_state == LOCKED) && routeRelieve[r_sel];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= FREE;
            r_status <= '0;
            r_sel    <= '0;
            r_locked <= 1'b0;
            r_count  <= '0;
            r_ptr    <= '0;
        end else begin
            case (r_state)
                FREE: begin
                    if (w_found) begin
                        r_state  <= LOCKED;
                        r_status <= N'(1) << w_win;
                        r_sel    <= w_win;
                        r_locked <= 1'b1;
                        r_count  <= sat_inc(r_count);
                        r_ptr    <= next_ptr(w_win);
                    end
                end
                LOCKED: begin
                    if (w_owner_relieve) begin
                        if (w_found) begin
                            r_status <= N'(1) << w_win;
                            r_sel    <= w_win;
                            r_count  <= sat_inc(r_count);
                            r_ptr    <= next_ptr(w_win);
                        end else begin
                            r_state  <= FREE;
                            r_status <= '0;
                            r_locked <= 1'b0;
                        end
                    end
                end
                default: r_state <= FREE;
            endcase
        end
    end

    assign routeReserveStatus = r_status;
    assign crossbarSelect     = r_sel;
    assign outputLocked       = r_locked;
    assign grantCount         = r_count;

endmodule
